// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
// State encoding and the default mul/div hold length live here so that the
// controller and any future users agree on them.
package hazard_pkg;

   // Controller states: RUN is normal flow, MD_BUSY holds EX for a mul/div.
   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } hz_state_e;

   // Default EX-stage hold length for a multiply/divide, in cycles (2..15).
   localparam int MD_CYCLES_DEF = 4;

   // Width of the mul/div down-counter; must hold MD_CYCLES-1 up to 14.
   localparam int MD_CNT_W = 4;

endpackage

// File: rtl/md_stall_counter.sv
// Loadable 4-bit down-counter that paces a mul/div stall.
// Latency: load/decrement take effect on the next rising edge; last is combinational.
// No backpressure: the counter moves whenever dec is high and never wraps below 0.
import hazard_pkg::*;

module md_stall_counter (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                load,
   input  logic [MD_CNT_W-1:0] load_val,
   input  logic                dec,
   output logic [MD_CNT_W-1:0] cnt,
   output logic                last
);

   logic [MD_CNT_W-1:0] cnt_q;
   logic [MD_CNT_W-1:0] cnt_d;

   // Next count: load wins over decrement; decrement stops at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - MD_CNT_W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   // Terminal flag: the current cycle is the final MD_BUSY cycle.
   assign last = (cnt_q == MD_CNT_W'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and, when
// HAZARD_MD_STALL_EN is defined, a MD_CYCLES-long EX hold for mul/div.
// Outputs are combinational from state and inputs; the stall counter saturates.
import hazard_pkg::*;

module hazard_ctrl #(
   parameter int MD_CYCLES = MD_CYCLES_DEF,
   parameter int CNT_W     = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [4:0]       Rs_ID,
   input  logic [4:0]       Rt_ID,
   input  logic [4:0]       Rt_EX,
   input  logic             MemRead_EX,
   input  logic             BranchTaken_EX,
   input  logic             MdStart_EX,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             ID_EX_Hold,
   output logic             Busy,
   output logic [CNT_W-1:0] StallCnt
);

   hz_state_e        state_q;
   hz_state_e        state_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;
   logic             load_use;

   // A load writing $0 never creates a real dependency.
   assign load_use = MemRead_EX && (Rt_EX != 5'd0) &&
                     ((Rt_EX == Rs_ID) || (Rt_EX == Rt_ID));

`ifdef HAZARD_MD_STALL_EN
   logic                md_load;
   logic                md_dec;
   logic                md_last;
   logic [MD_CNT_W-1:0] md_cnt;

   md_stall_counter u_md_cnt (
      .Clk      (Clk),
      .Rst      (Rst),
      .load     (md_load),
      .load_val (MD_CNT_W'(MD_CYCLES - 1)),
      .dec      (md_dec),
      .cnt      (md_cnt),
      .last     (md_last)
   );

   // The count value itself is only needed through the terminal flag.
   logic unused_md_cnt;
   assign unused_md_cnt = ^md_cnt;
`else
   // Mul/div support is compiled out: the start strobe has no effect.
   logic unused_md;
   assign unused_md = MdStart_EX | (MD_CYCLES == 0);
`endif

   // Next state and all pipeline control outputs; branch > mul/div > load-use.
   always_comb begin
      state_d     = state_q;
      PCWrite     = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b0;
      ID_EX_Hold  = 1'b0;
      Busy        = 1'b0;
`ifdef HAZARD_MD_STALL_EN
      md_load     = 1'b0;
      md_dec      = 1'b0;
`endif
      if (Rst) begin
         // Freeze fetch and bubble both stages while reset is held.
         state_d     = RUN;
         PCWrite     = 1'b0;
         IF_ID_Write = 1'b0;
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
      end else begin
         case (state_q)
`ifdef HAZARD_MD_STALL_EN
            MD_BUSY: begin
               // Branch, start and load-use are deliberately ignored here.
               PCWrite     = 1'b0;
               IF_ID_Write = 1'b0;
               ID_EX_Hold  = 1'b1;
               Busy        = 1'b1;
               md_dec      = 1'b1;
               if (md_last) begin
                  state_d = RUN;
               end
            end
`endif
            default: begin
               if (BranchTaken_EX) begin
                  IF_ID_Flush = 1'b1;
                  ID_EX_Flush = 1'b1;
`ifdef HAZARD_MD_STALL_EN
               end else if (MdStart_EX) begin
                  // The start cycle is the first of the MD_CYCLES held cycles.
                  PCWrite     = 1'b0;
                  IF_ID_Write = 1'b0;
                  ID_EX_Hold  = 1'b1;
                  md_load     = 1'b1;
                  state_d     = MD_BUSY;
`endif
               end else if (load_use) begin
                  PCWrite     = 1'b0;
                  IF_ID_Write = 1'b0;
                  ID_EX_Flush = 1'b1;
               end
            end
         endcase
      end
   end

   // Stall-cycle count: one per cycle with fetch frozen, saturating at all-ones.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!PCWrite && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // State and performance counter registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign StallCnt = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_CYCLES, default 4, giving the EX-stage hold length in cycles for a multiply/divide (legal range 2..15).
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of the stall-cycle performance counter.
REQ-003 SHALL have port Clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports Rs_ID and Rt_ID, input, 5 each: source register numbers of the instruction in ID.
REQ-006 SHALL have port Rt_EX, input, 5: destination register of the instruction in EX.
REQ-007 SHALL have port MemRead_EX, input, 1: the instruction in EX is a load.
REQ-008 SHALL have port BranchTaken_EX, input, 1: the branch in EX resolved taken.
REQ-009 SHALL have port MdStart_EX, input, 1: a mul/div entered EX this cycle.
REQ-010 SHALL have ports PCWrite and IF_ID_Write, output, 1 each: update enables for the PC and the IF/ID register.
REQ-011 SHALL have ports IF_ID_Flush and ID_EX_Flush, output, 1 each: zero the IF/ID register, or zero ControlUnitOut in the ID/EX register (bubble).
REQ-012 SHALL have port ID_EX_Hold, output, 1: ID/EX keeps its current contents.
REQ-013 SHALL have port Busy, output, 1: mul/div stall in progress.
REQ-014 SHALL have port StallCnt, output, CNT_W: number of stall cycles since reset.

Function
REQ-015 SHALL implement states RUN and MD_BUSY, with a registered state and a registered 4-bit down-counter.
- Outputs are combinational from the current state and the inputs.
- Default in RUN with no event: PCWrite=1, IF_ID_Write=1, all other 1-bit outputs 0.
REQ-016 SHALL detect load-use in RUN when MemRead_EX=1, Rt_EX!=0, and Rt_EX equals Rs_ID or Rt_ID.
- Same cycle: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
- State stays RUN; one bubble per hazard.
REQ-017 SHALL flush on BranchTaken_EX=1 in RUN.
- Same cycle: PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1.
- Priority: branch overrides load-use.
REQ-018 SHALL handle MdStart_EX=1 in RUN (macro enabled) as follows.
- Next state MD_BUSY; counter loaded with MD_CYCLES-1.
- The start cycle itself stalls: PCWrite=0, IF_ID_Write=0, ID_EX_Hold=1.
- Priority: MdStart_EX overrides load-use; branch overrides MdStart_EX.
REQ-019 SHALL behave in MD_BUSY as follows.
- Outputs: PCWrite=0, IF_ID_Write=0, ID_EX_Hold=1, Busy=1.
- The counter decrements each cycle; when the counter is 1, next state is RUN.
- The total hold is exactly MD_CYCLES cycles, including the start cycle.
REQ-020 SHALL ignore BranchTaken_EX, MdStart_EX and load-use inputs while in MD_BUSY.
REQ-021 SHALL never assert ID_EX_Hold and ID_EX_Flush in the same cycle.
REQ-022 SHALL increment StallCnt in every cycle with PCWrite=0 and Rst=0, saturating at all-ones without wrap.

Reset
REQ-023 SHALL, on a rising edge with Rst=1, set state=RUN, counter=0, StallCnt=0, including mid-MD_BUSY.
REQ-024 SHALL, while Rst=1, drive PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, ID_EX_Hold=0, Busy=0.

Configuration
REQ-025 SHALL compile in the mul/div stall logic only when HAZARD_MD_STALL_EN is defined.
- Undefined: MdStart_EX is ignored, MD_BUSY is unreachable, Busy is tied to 0, and the counter is not instantiated.

Structure
REQ-026 SHALL take the state encoding (RUN=0, MD_BUSY=1) and the MD_CYCLES default from shared package hazard_pkg.
REQ-027 SHALL place the load/decrement counter with its terminal flag in sub-module md_stall_counter.

Verification
REQ-028 SHALL cover load-use: MemRead_EX=1, Rt_EX=3, Rs_ID=3 -> one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; StallCnt=1.
REQ-029 SHALL cover the $0 exception: MemRead_EX=1, Rt_EX=0, Rs_ID=0 -> no stall, PCWrite=1.
REQ-030 SHALL cover branch priority: BranchTaken_EX=1 together with a load-use match -> IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1.
REQ-031 SHALL cover mul/div with MD_CYCLES=4 and the macro defined: MdStart_EX pulse -> ID_EX_Hold=1 for exactly 4 cycles and Busy=1 for 3; StallCnt=4.
REQ-032 SHALL cover reset mid-busy: Rst=1 in the 2nd MD_BUSY cycle -> next cycle state RUN, Busy=0, StallCnt=0.
REQ-033 SHALL cover the macro undefined: MdStart_EX=1 -> PCWrite=1, Busy=0.
